// File: rtl/frame_reception.sv
// Receive-side Ethernet framer: hunts preamble/SFD, de-serialises header, payload and FCS,
// and checks CRC-32 over the 18 content bytes before reporting each frame.
module frame_reception #(
  parameter int          MIN_PRE     = 7,
  parameter int          GAP_TIMEOUT = 16,
  parameter logic [47:0] MAC_ADDR    = 48'h0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  output logic [47:0] dest_addr,
  output logic [47:0] src_addr,
  output logic [15:0] eth_type,
  output logic [31:0] data_out,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        addr_match,
  output logic        frame_abort,
  output logic        busy,
  output logic [3:0]  state,
  output logic [2:0]  byte_count
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PREAMBLE  = 4'd1,
    DEST_ADDR = 4'd2,
    SRC_ADDR  = 4'd3,
    ETH_TYPE  = 4'd4,
    PAYLOAD   = 4'd5,
    FCS       = 4'd6,
    CHECK     = 4'd7
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [7:0]  GAP_LIM  = 8'(GAP_TIMEOUT);
  localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;

  state_t      state_q;
  logic [3:0]  pre_cnt;
  logic [7:0]  gap_cnt;
  logic [2:0]  byte_cnt;
  logic [31:0] crc_reg;
  logic [47:0] dest_sh;
  logic [47:0] src_sh;
  logic [15:0] type_sh;
  logic [31:0] data_sh;
  logic [31:0] fcs_sh;

  // Reflected CRC-32 update, data bits consumed LSB-first.
  function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = {1'b0, c[31:1]} ^ CRC_POLY;
      else             c = {1'b0, c[31:1]};
    end
    return c;
  endfunction

  assign state      = state_q;
  assign byte_count = byte_cnt;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pre_cnt     <= 4'd0;
      gap_cnt     <= 8'd0;
      byte_cnt    <= 3'd0;
      crc_reg     <= CRC_INIT;
      dest_sh     <= 48'd0;
      src_sh      <= 48'd0;
      type_sh     <= 16'd0;
      data_sh     <= 32'd0;
      fcs_sh      <= 32'd0;
      dest_addr   <= 48'd0;
      src_addr    <= 48'd0;
      eth_type    <= 16'd0;
      data_out    <= 32'd0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      addr_match  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state_q)
        IDLE: begin
          gap_cnt  <= 8'd0;
          byte_cnt <= 3'd0;
          if (rx_dv && rx_data == 8'hAA) begin
            state_q <= PREAMBLE;
            pre_cnt <= 4'd1;
          end
        end

        PREAMBLE, DEST_ADDR, SRC_ADDR, ETH_TYPE, PAYLOAD, FCS: begin
          if (!rx_dv) begin
            // Idle gap: abandon the frame once the gap reaches the limit;
            // only frames already past SFD are reported as aborted.
            if (gap_cnt + 8'd1 == GAP_LIM) begin
              state_q     <= IDLE;
              gap_cnt     <= 8'd0;
              pre_cnt     <= 4'd0;
              byte_cnt    <= 3'd0;
              frame_abort <= (state_q != PREAMBLE);
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end else begin
            gap_cnt <= 8'd0;
            case (state_q)
              PREAMBLE: begin
                if (rx_data == 8'hAA) begin
                  if (pre_cnt != 4'd15) pre_cnt <= pre_cnt + 4'd1;
                end else if (rx_data == 8'hAB && int'(pre_cnt) >= MIN_PRE) begin
                  state_q  <= DEST_ADDR;
                  byte_cnt <= 3'd0;
                  crc_reg  <= CRC_INIT;
                  pre_cnt  <= 4'd0;
                end else begin
                  state_q <= IDLE;
                  pre_cnt <= 4'd0;
                end
              end

              DEST_ADDR: begin
                dest_sh <= {dest_sh[39:0], rx_data};
                crc_reg <= crc_next(crc_reg, rx_data);
                if (byte_cnt == 3'd5) begin
                  state_q  <= SRC_ADDR;
                  byte_cnt <= 3'd0;
                end else begin
                  byte_cnt <= byte_cnt + 3'd1;
                end
              end

              SRC_ADDR: begin
                src_sh  <= {src_sh[39:0], rx_data};
                crc_reg <= crc_next(crc_reg, rx_data);
                if (byte_cnt == 3'd5) begin
                  state_q  <= ETH_TYPE;
                  byte_cnt <= 3'd0;
                end else begin
                  byte_cnt <= byte_cnt + 3'd1;
                end
              end

              ETH_TYPE: begin
                type_sh <= {type_sh[7:0], rx_data};
                crc_reg <= crc_next(crc_reg, rx_data);
                if (byte_cnt == 3'd1) begin
                  state_q  <= PAYLOAD;
                  byte_cnt <= 3'd0;
                end else begin
                  byte_cnt <= byte_cnt + 3'd1;
                end
              end

              PAYLOAD: begin
                data_sh <= {data_sh[23:0], rx_data};
                crc_reg <= crc_next(crc_reg, rx_data);
                if (byte_cnt == 3'd3) begin
                  state_q  <= FCS;
                  byte_cnt <= 3'd0;
                end else begin
                  byte_cnt <= byte_cnt + 3'd1;
                end
              end

              FCS: begin
                // FCS arrives MSB-first and is not folded into the CRC.
                fcs_sh <= {fcs_sh[23:0], rx_data};
                if (byte_cnt == 3'd3) begin
                  state_q  <= CHECK;
                  byte_cnt <= 3'd0;
                end else begin
                  byte_cnt <= byte_cnt + 3'd1;
                end
              end

              default: state_q <= IDLE;
            endcase
          end
        end

        CHECK: begin
          // Input bytes in this cycle are dropped on purpose.
          dest_addr  <= dest_sh;
          src_addr   <= src_sh;
          eth_type   <= type_sh;
          data_out   <= data_sh;
          crc_ok     <= (fcs_sh == ~crc_reg);
          addr_match <= (dest_sh == MAC_ADDR) || (dest_sh == BCAST);
          frame_done <= 1'b1;
          state_q    <= IDLE;
          gap_cnt    <= 8'd0;
          byte_cnt   <= 3'd0;
        end

        default: begin
          state_q  <= IDLE;
          pre_cnt  <= 4'd0;
          gap_cnt  <= 8'd0;
          byte_cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reception.sv
// Directed self-checking bench for frame_reception: good/bad CRC, gaps, aborts,
// preamble errors, address filtering and mid-frame reset.
module tb_frame_reception;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic [47:0] dest_addr;
  logic [47:0] src_addr;
  logic [15:0] eth_type;
  logic [31:0] data_out;
  logic        frame_done;
  logic        crc_ok;
  logic        addr_match;
  logic        frame_abort;
  logic        busy;
  logic [3:0]  state;
  logic [2:0]  byte_count;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;
  int abortCount  = 0;

  logic [7:0] frameBytes [22];

  localparam logic [47:0] STATION = 48'h0200_0000_0001;

  frame_reception #(.MIN_PRE(7), .GAP_TIMEOUT(16), .MAC_ADDR(STATION)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_dv(rx_dv),
    .dest_addr(dest_addr), .src_addr(src_addr), .eth_type(eth_type),
    .data_out(data_out), .frame_done(frame_done), .crc_ok(crc_ok),
    .addr_match(addr_match), .frame_abort(frame_abort), .busy(busy),
    .state(state), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (frame_done)  doneCount++;
    if (frame_abort) abortCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic dv);
    @(negedge clk);
    rx_data = d;
    rx_dv   = dv;
  endtask

  // Bench reference CRC-32 (reflected, masked-xor form).
  function automatic logic [31:0] refCrc(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    logic        fb;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ frameBytes[k][b];
        c  = (c >> 1) ^ (32'hEDB8_8320 & {32{fb}});
      end
    return ~c;
  endfunction

  task automatic buildFrame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input logic [31:0] p);
    logic [31:0] fcs;
    for (int i = 0; i < 6; i++) frameBytes[i]    = d[47-8*i -: 8];
    for (int i = 0; i < 6; i++) frameBytes[6+i]  = s[47-8*i -: 8];
    for (int i = 0; i < 2; i++) frameBytes[12+i] = t[15-8*i -: 8];
    for (int i = 0; i < 4; i++) frameBytes[14+i] = p[31-8*i -: 8];
    fcs = refCrc(18);
    for (int i = 0; i < 4; i++) frameBytes[18+i] = fcs[31-8*i -: 8];
  endtask

  task automatic sendPreamble(input int n);
    applyStimulus(8'h00, 1'b1);
    for (int i = 0; i < n; i++) applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'hAB, 1'b1);
  endtask

  task automatic sendBody(input int first, input int last, input int gapAfter, input int gapLen);
    for (int i = first; i <= last; i++) begin
      if (i == gapAfter)
        for (int g = 0; g < gapLen; g++) applyStimulus(8'h5A, 1'b0);
      applyStimulus(frameBytes[i], 1'b1);
    end
  endtask

  // Called right after the last FCS byte has been driven.
  task automatic checkFrame(input string tag, input logic [47:0] expDest, input logic [47:0] expSrc,
                            input logic [15:0] expType, input logic [31:0] expData,
                            input logic expCrc, input logic expMatch);
    int doneBefore = doneCount;
    applyStimulus(8'hAA, 1'b1);
    checkOutput({tag, "_check_state"}, 64'(state), 64'd7);
    checkOutput({tag, "_done_early"}, 64'(frame_done), 64'd0);
    applyStimulus(8'h00, 1'b0);
    checkOutput({tag, "_done"}, 64'(frame_done), 64'd1);
    checkOutput({tag, "_dest"}, 64'(dest_addr), 64'(expDest));
    checkOutput({tag, "_src"}, 64'(src_addr), 64'(expSrc));
    checkOutput({tag, "_type"}, 64'(eth_type), 64'(expType));
    checkOutput({tag, "_data"}, 64'(data_out), 64'(expData));
    checkOutput({tag, "_crc_ok"}, 64'(crc_ok), 64'(expCrc));
    checkOutput({tag, "_addr_match"}, 64'(addr_match), 64'(expMatch));
    checkOutput({tag, "_idle"}, 64'(state), 64'd0);
    applyStimulus(8'h00, 1'b0);
    checkOutput({tag, "_done_width"}, 64'(frame_done), 64'd0);
    checkOutput({tag, "_done_count"}, 64'(doneCount - doneBefore), 64'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_dest"}, 64'(dest_addr), 64'd0);
    checkOutput({tag, "_src"}, 64'(src_addr), 64'd0);
    checkOutput({tag, "_type_data"}, {16'd0, eth_type, data_out}, 64'd0);
    checkOutput({tag, "_flags"}, {58'd0, frame_done, crc_ok, addr_match, frame_abort, busy, 1'b0}, 64'd0);
    checkOutput({tag, "_state"}, {57'd0, state, byte_count}, 64'd0);
  endtask

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC   = 48'h0011_2233_4455;

  initial begin
    int abortBefore;
    int doneBefore;
    rx_data = 8'h00;
    rx_dv   = 1'b0;
    rst_n   = 1'b0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Good broadcast frame, contiguous; leading 0x00 must be ignored.
    buildFrame(BCAST, SRC, 16'h0800, 32'hDEAD_BEEF);
    applyStimulus(8'h00, 1'b1);
    checkOutput("lead_zero_idle", 64'(state), 64'd0);
    sendPreamble(7);
    sendBody(0, 21, -1, 0);
    checkFrame("good", BCAST, SRC, 16'h0800, 32'hDEAD_BEEF, 1'b1, 1'b1);

    // Payload BE -> BF after FCS computed for BE.
    buildFrame(BCAST, SRC, 16'h0800, 32'hDEAD_BEEF);
    frameBytes[16] = 8'hBF;
    sendPreamble(7);
    sendBody(0, 21, -1, 0);
    checkFrame("badcrc", BCAST, SRC, 16'h0800, 32'hDEAD_BFEF, 1'b0, 1'b1);

    // Five idle cycles between payload and FCS are tolerated.
    buildFrame(BCAST, SRC, 16'h0800, 32'hDEAD_BEEF);
    sendPreamble(7);
    sendBody(0, 21, 18, 5);
    checkFrame("gap5", BCAST, SRC, 16'h0800, 32'hDEAD_BEEF, 1'b1, 1'b1);

    // Sixteen idle cycles after the source address abort the frame.
    buildFrame(STATION, 48'hAABB_CCDD_EEFF, 16'h86DD, 32'h1234_5678);
    abortBefore = abortCount;
    doneBefore  = doneCount;
    sendPreamble(7);
    sendBody(0, 11, -1, 0);
    for (int g = 0; g < 16; g++) applyStimulus(8'h00, 1'b0);
    checkOutput("abort_pre_state", 64'(state), 64'd4);
    checkOutput("abort_pre_pulse", 64'(frame_abort), 64'd0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("abort_pulse", 64'(frame_abort), 64'd1);
    checkOutput("abort_idle", 64'(state), 64'd0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("abort_width", 64'(frame_abort), 64'd0);
    checkOutput("abort_count", 64'(abortCount - abortBefore), 64'd1);
    checkOutput("abort_no_done", 64'(doneCount - doneBefore), 64'd0);
    checkOutput("abort_keep_data", 64'(data_out), 64'hDEAD_BEEF);
    checkOutput("abort_keep_dest", 64'(dest_addr), 64'(BCAST));
    checkOutput("abort_keep_flags", {62'd0, crc_ok, addr_match}, 64'd3);

    // Short preamble: 6 x AA then AB.
    doneBefore  = doneCount;
    abortBefore = abortCount;
    for (int i = 0; i < 6; i++) applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'hAB, 1'b1);
    checkOutput("short_pre_state", 64'(state), 64'd1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("short_pre_idle", 64'(state), 64'd0);
    // AA AA 55 drops the hunt.
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'h55, 1'b1);
    checkOutput("bad_pre_busy", 64'(busy), 64'd1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("bad_pre_idle", 64'(state), 64'd0);
    checkOutput("bad_pre_no_pulses", 64'(doneCount - doneBefore + abortCount - abortBefore), 64'd0);
    buildFrame(48'h0200_0000_0002, SRC, 16'h0806, 32'hCAFE_F00D);
    sendPreamble(7);
    sendBody(0, 21, -1, 0);
    checkFrame("other_station", 48'h0200_0000_0002, SRC, 16'h0806, 32'hCAFE_F00D, 1'b1, 1'b0);

    buildFrame(STATION, SRC, 16'h0800, 32'h0102_0304);
    sendPreamble(7);
    sendBody(0, 21, -1, 0);
    checkFrame("own_station", STATION, SRC, 16'h0800, 32'h0102_0304, 1'b1, 1'b1);

    // Reset asserted during the source address.
    doneBefore  = doneCount;
    abortBefore = abortCount;
    buildFrame(BCAST, SRC, 16'h0800, 32'hDEAD_BEEF);
    sendPreamble(7);
    sendBody(0, 8, -1, 0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("pre_reset_state", 64'(state), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midreset_no_pulses", 64'(doneCount - doneBefore + abortCount - abortBefore), 64'd0);
    sendPreamble(7);
    sendBody(0, 21, -1, 0);
    checkFrame("after_reset", BCAST, SRC, 16'h0800, 32'hDEAD_BEEF, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/frame_reception.md
# frame_reception

Receive-side framer for the Ethernet MAC. It consumes the byte stream produced by the MAC transmit path or the PHY-side loopback: an 8-bit data byte plus a per-byte valid qualifier. It hunts for preamble and SFD, then de-serialises destination address, source address, EtherType, a 4-byte payload and the 4-byte FCS. The block checks CRC-32 over the frame contents and reports each completed frame with a one-cycle status pulse and registered header and payload fields.

## Interface
- MIN_PRE, default 7: minimum number of consecutive 0xAA bytes required before SFD.
- GAP_TIMEOUT, default 16: consecutive idle (rx_dv=0) cycles after which a frame in progress is aborted. Range 1..255.
- MAC_ADDR, default 48'h0000_0000_0000: station address used for address filtering.
- clk  in  1  system clock. All flops are rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte.
- rx_dv  in  1  rx_data is valid this cycle. Bytes are consumed only when rx_dv=1; gaps are permitted.
- dest_addr  out  48  destination address of the last completed frame. First byte received is [47:40].
- src_addr  out  48  source address of the last completed frame, same byte order.
- eth_type  out  16  EtherType. First byte received is [15:8].
- data_out  out  32  payload. First byte received is [31:24].
- frame_done  out  1  one-cycle pulse when a frame completes (good or bad CRC).
- crc_ok  out  1  registered with frame_done; 1 when received FCS equals computed CRC. Held until the next frame_done.
- addr_match  out  1  registered with frame_done; 1 when dest_addr==MAC_ADDR or dest_addr==48'hFFFF_FFFF_FFFF. Held until the next frame_done.
- frame_abort  out  1  one-cycle pulse when a frame past SFD is abandoned on gap timeout.
- busy  out  1  FSM is not in IDLE.
- state  out  4  current FSM state, for observation.
- byte_count  out  3  byte index within the current field, for observation.

## Operation
- Reset values: all outputs 0; state=IDLE; CRC register 32'hFFFF_FFFF; all counters 0.
- State encoding:
  - IDLE=0, PREAMBLE=1, DEST_ADDR=2, SRC_ADDR=3, ETH_TYPE=4, PAYLOAD=5, FCS=6, CHECK=7.
  - Any other code returns to IDLE on the next edge.
- IDLE:
  - Valid 0xAA moves to PREAMBLE with pre_cnt=1.
  - Any other valid byte, including 0x00, is ignored.
- PREAMBLE:
  - Valid 0xAA increments pre_cnt, saturating at 15.
  - Valid 0xAB with pre_cnt>=MIN_PRE moves to DEST_ADDR with byte_count=0 and CRC=FFFF_FFFF.
  - Valid 0xAB with pre_cnt<MIN_PRE, or any other valid byte, returns to IDLE silently.
- Field states consume these numbers of valid bytes, MSB-first into shadow registers, then advance with byte_count reset to 0:
  - DEST_ADDR: 6 bytes.
  - SRC_ADDR: 6 bytes.
  - ETH_TYPE: 2 bytes.
  - PAYLOAD: 4 bytes.
  - FCS: 4 bytes.
- CRC computation:
  - IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, init FFFF_FFFF.
  - Each byte is processed LSB-first.
  - The CRC is updated on every valid byte in DEST_ADDR through PAYLOAD (18 bytes). FCS bytes are not fed to the CRC.
  - The final CRC is the register XOR FFFF_FFFF.
  - The FCS is received MSB-first: the first FCS byte is fcs[31:24].
- CHECK, one cycle, no input consumed:
  - Copy the shadow registers to the output fields.
  - Set crc_ok = (fcs == final CRC) and set addr_match.
  - Pulse frame_done.
  - Go to IDLE.
- Gap timeout:
  - gap_cnt counts consecutive rx_dv=0 cycles in PREAMBLE through FCS and clears on any valid byte.
  - On reaching GAP_TIMEOUT in PREAMBLE: go to IDLE silently.
  - On reaching GAP_TIMEOUT in DEST_ADDR through FCS: pulse frame_abort and go to IDLE. Output fields, crc_ok and addr_match are unchanged.
- rx_data is ignored when rx_dv=0.
- 0xAA or 0xAB bytes after SFD are ordinary data.
- Bytes arriving in CHECK are dropped. Any valid byte arriving in the CHECK cycle is not counted toward a new preamble.
- An rst_n assertion mid-frame returns every register to its reset value immediately. No frame_done or frame_abort is produced for that frame.

## Timing
- Latency: the 4th FCS byte is sampled at edge E; state=CHECK after E; frame_done, crc_ok, addr_match and the fields update at edge E+1. frame_done is high for exactly one cycle.
- Back-to-back: a new preamble may start with the byte presented in the cycle after frame_done rises.
- A frame_abort pulse rises on the edge where gap_cnt reaches GAP_TIMEOUT.
- Minimum frame duration is MIN_PRE+1+22 valid bytes plus 1 CHECK cycle.

## Test plan
- Good frame, contiguous: 0x00, 7×AA, AB, dest FF:FF:FF:FF:FF:FF, src 00:11:22:33:44:55, type 0x0800, payload DE AD BE EF, then the bench-model CRC-32 as 4 bytes MSB-first -> a single frame_done exactly 1 cycle after the last FCS byte; crc_ok=1; addr_match=1; data_out=DEADBEEF; eth_type=0800.
- Same frame with payload byte BE replaced by BF -> frame_done with crc_ok=0; fields updated; data_out=DEADBFEF.
- Same frame with 5 idle cycles inserted between payload and FCS (GAP_TIMEOUT=16) -> crc_ok=1. Same frame with a 16-cycle gap after src_addr -> frame_abort pulse, no frame_done, outputs retain the prior frame's values.
- Preamble errors: 6×AA then AB -> stays/returns IDLE with no pulses; AA AA 55 AA… -> IDLE on 55, then a full valid frame is still accepted.
- MAC_ADDR=02:00:00:00:00:01 with dest 02:00:00:00:00:02 -> addr_match=0, crc_ok=1; dest 02:00:00:00:00:01 -> addr_match=1.
- rst_n pulsed low during SRC_ADDR -> all outputs 0 asynchronously, state=IDLE, no pulses; a following complete frame is received correctly.
